// File: rtl/sw_debounce.sv
// Switch/pushbutton debouncer: two-flop synchronizer feeding a four-state
// stability FSM, with registered edge pulses, a T flip-flop and a rise counter.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_raw,
  output logic       sw_level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       toggle_q,
  output logic [7:0] rise_count
);

  localparam logic [19:0] N = 20'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  logic        sync_meta;
  logic        sync;
  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        level_nxt;
  logic        rise_nxt;
  logic        fall_nxt;

  // sync_meta may go metastable; only sync is allowed to reach the FSM.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = sw_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (sync) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = 20'd1;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == N) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 20'd1;
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = 20'd1;
        end else begin
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == N) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 20'd1;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses, level, toggle and counter all update on the edge that accepts the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      sw_level   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      toggle_q   <= 1'b0;
      rise_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sw_level   <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      toggle_q   <= toggle_q ^ rise_nxt;
      rise_count <= rise_count + 8'(rise_nxt);
    end
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the N consecutive stable synchronized samples required after first change (legal range 1..2^20-1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sw_raw  input  1  raw slide-switch/pushbutton level, asynchronous to clk, may bounce.
REQ-005 SHALL have port sw_level  output  1  debounced registered level.
REQ-006 SHALL have port rise_pulse  output  1  one-cycle pulse on debounced 0->1.
REQ-007 SHALL have port fall_pulse  output  1  one-cycle pulse on debounced 1->0.
REQ-008 SHALL have port toggle_q  output  1  flips on every rise_pulse (T flip-flop behaviour).
REQ-009 SHALL have port rise_count  output  8  number of rise_pulse events, modulo 256.

Function
REQ-010 SHALL pass sw_raw through a two-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-011 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW and a 20-bit counter cnt.
REQ-012 IDLE_LOW: sync=1 -> WAIT_HIGH, cnt<=1; else stay, cnt<=0.
REQ-013 WAIT_HIGH: sync=0 -> IDLE_LOW, cnt<=0; else if cnt==N -> IDLE_HIGH, sw_level<=1, rise_pulse<=1, cnt<=0; else cnt<=cnt+1.
REQ-014 IDLE_HIGH / WAIT_LOW SHALL mirror REQ-012/013 with polarity inverted, asserting fall_pulse and clearing sw_level.
REQ-015 A sw_raw change held for exactly N clocks SHALL be rejected; held for N+1 or more clocks SHALL be accepted.
REQ-016 Latency: with sw_raw stable after a change, sw_level and the pulse SHALL update on the (N+3)rd rising edge sampling the new value.
REQ-017 rise_pulse and fall_pulse SHALL be registered, high for exactly one cycle, never simultaneously high.
REQ-018 Any reversion of sync during WAIT_x SHALL return to the originating IDLE_x with no pulse and cnt cleared; bounce restarts the count.
REQ-019 toggle_q SHALL invert on the same edge rise_pulse is asserted; fall_pulse has no effect on it.
REQ-020 rise_count SHALL increment on the same edge rise_pulse is asserted, wrapping 255->0 with no flag.
REQ-021 cnt SHALL never exceed N; no combinational path from sw_raw to any output.

Reset
REQ-022 rst_n=0 SHALL immediately force sync flops=0, state IDLE_LOW, cnt=0, sw_level=0, rise_pulse=0, fall_pulse=0, toggle_q=0, rise_count=0.
REQ-023 Reset asserted mid-WAIT SHALL abort the pending transition with no pulse after release.
REQ-024 If sw_raw=1 at reset release, the block SHALL debounce it normally and emit one rise_pulse N+3 cycles after release.

Verification (N=4)
REQ-025 Reset, sw_raw 0->1 held -> sw_level=1, rise_pulse high one cycle on 7th edge, toggle_q=1, rise_count=1.
REQ-026 sw_raw high exactly 4 cycles then low -> no pulse, sw_level stays 0; high 5 cycles then low -> one rise_pulse, then fall_pulse after 7 low cycles.
REQ-027 Bounce pattern 1,0,1,1,0,1 then steady 1 -> exactly one rise_pulse, 7 cycles after last 0->1.
REQ-028 256 clean press/release pairs -> rise_count wraps 255->0, toggle_q back to 0, 256 fall_pulses.
REQ-029 rst_n pulsed low while in WAIT_HIGH with cnt=3 -> all outputs 0 asynchronously, no pulse; sw_raw still 1 -> rise_pulse 7 cycles after release.
